// File: rtl/rgmii_tx_ddr_fmt_pkg.sv
// Shared Ethernet definitions for the RGMII transmit formatter and its helpers.
// Speed encodings match the MAC link-speed select.
package rgmii_tx_ddr_fmt_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  // 2'b11 is treated as gigabit, so only the upper bit matters.
  function automatic logic is_gig(input logic [1:0] spd);
    return spd[1];
  endfunction

endpackage

// File: rtl/rgmii_clk_pattern.sv
// Forwarded-clock pattern for one RGMII clock period of div system cycles.
// Gives a 50% duty cycle to half-cycle resolution; shared with the rx-side clock checker.
module rgmii_clk_pattern #(
  parameter int unsigned CntW = 6
) (
  input  logic [CntW-1:0] cnt,
  input  logic [CntW-1:0] div,
  output logic            clk_q1,
  output logic            clk_q2
);

  logic [CntW-1:0] half;
  logic            first_half;

  always_comb begin
    half       = div >> 1;
    first_half = (cnt < half);
    // Odd divisors spend half a cycle high in the middle slot.
    clk_q1     = first_half | ((cnt == half) & div[0]);
    clk_q2     = first_half;
  end

endmodule

// File: rtl/rgmii_tx_ddr_fmt.sv
// Turns a GMII byte stream into per-edge q1/q2 pairs for the RGMII tx oddr cells.
// Gigabit sends one byte per cycle; 10/100 sends each nibble for one full RGMII clock period.
module rgmii_tx_ddr_fmt
  import rgmii_tx_ddr_fmt_pkg::*;
#(
  parameter int unsigned CLK_DIV_100 = 5,
  parameter int unsigned CLK_DIV_10  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_en,
  input  logic       gmii_tx_er,
  output logic       gmii_clk_en,
  output logic [3:0] txd_q1,
  output logic [3:0] txd_q2,
  output logic       ctl_q1,
  output logic       ctl_q2,
  output logic       clk_q1,
  output logic       clk_q2
);

  localparam int unsigned DivMax = (CLK_DIV_10 > CLK_DIV_100) ? CLK_DIV_10 : CLK_DIV_100;
  localparam int unsigned CntW   = $clog2(DivMax + 1);

  localparam logic [CntW-1:0] Div10  = CntW'(CLK_DIV_10);
  localparam logic [CntW-1:0] Div100 = CntW'(CLK_DIV_100);

  function automatic logic [CntW-1:0] div_for(input logic [1:0] spd);
    return (spd == SPEED_10) ? Div10 : Div100;
  endfunction

  logic [1:0]      spd_q, spd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic [3:0]      hold_hi_q, hold_hi_d;
  logic [3:0]      txd1_q, txd1_d, txd2_q, txd2_d;
  logic            ctl1_q, ctl1_d, ctl2_q, ctl2_d;
  logic            clk1_q, clk1_d, clk2_q, clk2_d;

  logic [CntW-1:0] div_cur;
  logic [CntW-1:0] div_nxt;
  logic            pat_q1, pat_q2;

  assign div_cur     = div_for(spd_q);
  assign gmii_clk_en = ~rst & (is_gig(spd_q) | ((cnt_q == div_cur - 1'b1) & phase_q));

  always_comb begin
    spd_d     = spd_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    hold_hi_d = hold_hi_q;
    txd1_d    = txd1_q;
    txd2_d    = txd2_q;
    ctl1_d    = ctl1_q;
    ctl2_d    = ctl2_q;
    if (gmii_clk_en) begin
      spd_d     = speed;
      cnt_d     = '0;
      phase_d   = 1'b0;
      hold_hi_d = gmii_txd[7:4];
      ctl1_d    = gmii_tx_en;
      ctl2_d    = gmii_tx_en ^ gmii_tx_er;
      txd1_d    = gmii_txd[3:0];
      txd2_d    = is_gig(speed) ? gmii_txd[7:4] : gmii_txd[3:0];
    end else if (!is_gig(spd_q)) begin
      if (cnt_q == div_cur - 1'b1) begin
        cnt_d = '0;
        if (!phase_q) begin
          phase_d = 1'b1;
          txd1_d  = hold_hi_q;
          txd2_d  = hold_hi_q;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign div_nxt = div_for(spd_d);

  // Pattern is looked up for the count the registers will hold after this edge.
  rgmii_clk_pattern #(
    .CntW(CntW)
  ) u_clk_pattern (
    .cnt    (cnt_d),
    .div    (div_nxt),
    .clk_q1 (pat_q1),
    .clk_q2 (pat_q2)
  );

  always_comb begin
    clk1_d = is_gig(spd_d) ? 1'b1 : pat_q1;
    clk2_d = is_gig(spd_d) ? 1'b0 : pat_q2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spd_q     <= SPEED_1000;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      hold_hi_q <= 4'h0;
      txd1_q    <= 4'h0;
      txd2_q    <= 4'h0;
      ctl1_q    <= 1'b0;
      ctl2_q    <= 1'b0;
      clk1_q    <= 1'b0;
      clk2_q    <= 1'b0;
    end else begin
      spd_q     <= spd_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      hold_hi_q <= hold_hi_d;
      txd1_q    <= txd1_d;
      txd2_q    <= txd2_d;
      ctl1_q    <= ctl1_d;
      ctl2_q    <= ctl2_d;
      clk1_q    <= clk1_d;
      clk2_q    <= clk2_d;
    end
  end

  assign txd_q1 = txd1_q;
  assign txd_q2 = txd2_q;
  assign ctl_q1 = ctl1_q;
  assign ctl_q2 = ctl2_q;
  assign clk_q1 = clk1_q;
  assign clk_q2 = clk2_q;

endmodule

// File: tb/tb_rgmii_tx_ddr_fmt.sv
// Directed bench for rgmii_tx_ddr_fmt: each accepted byte pushes its per-cycle
// output sequence to a scoreboard that is popped and checked after every edge.
module tb_rgmii_tx_ddr_fmt;

  localparam int unsigned Div100 = 5;
  localparam int unsigned Div10  = 50;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d2;
    logic       c1;
    logic       c2;
    logic       k1;
    logic       k2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] speed = 2'b10;
  logic [7:0] gmii_txd = 8'h00;
  logic       gmii_tx_en = 1'b0;
  logic       gmii_tx_er = 1'b0;
  logic       gmii_clk_en;
  logic [3:0] txd_q1, txd_q2;
  logic       ctl_q1, ctl_q2, clk_q1, clk_q2;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #4 clk = ~clk;

  rgmii_tx_ddr_fmt #(
    .CLK_DIV_100 (Div100),
    .CLK_DIV_10  (Div10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .speed       (speed),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .gmii_clk_en (gmii_clk_en),
    .txd_q1      (txd_q1),
    .txd_q2      (txd_q2),
    .ctl_q1      (ctl_q1),
    .ctl_q2      (ctl_q2),
    .clk_q1      (clk_q1),
    .clk_q2      (clk_q2)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle outputs for one byte at the given speed.
  task automatic push_byte(input logic [1:0] spd, input logic [7:0] d, input logic en,
                           input logic er);
    exp_t e;
    int   n, h, c;
    e.c1 = en;
    e.c2 = en ^ er;
    if (spd[1]) begin
      e.d1 = d[3:0];
      e.d2 = d[7:4];
      e.k1 = 1'b1;
      e.k2 = 1'b0;
      sb.push_back(e);
    end else begin
      n = (spd == 2'b00) ? Div10 : Div100;
      h = n / 2;
      for (int k = 0; k < 2 * n; k++) begin
        c    = k % n;
        e.d1 = (k < n) ? d[3:0] : d[7:4];
        e.d2 = e.d1;
        e.k1 = (c < h) || ((c == h) && (n % 2 == 1));
        e.k2 = (c < h);
        sb.push_back(e);
      end
    end
  endtask

  // One clock: record a capture if the strobe is up, then check the outputs after the edge.
  task automatic cycle(output logic captured);
    exp_t e;
    captured = gmii_clk_en;
    if (captured) push_byte(speed, gmii_txd, gmii_tx_en, gmii_tx_er);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      check("txd_q1", {4'h0, txd_q1}, {4'h0, e.d1});
      check("txd_q2", {4'h0, txd_q2}, {4'h0, e.d2});
      check("ctl", {6'h0, ctl_q1, ctl_q2}, {6'h0, e.c1, e.c2});
      check("clk_pat", {6'h0, clk_q1, clk_q2}, {6'h0, e.k1, e.k2});
      check("clk_en", {7'h0, gmii_clk_en}, {7'h0, sb.size() == 0});
    end
  endtask

  task automatic send(input logic [1:0] spd, input logic [7:0] d, input logic en,
                      input logic er);
    logic cap;
    speed      = spd;
    gmii_txd   = d;
    gmii_tx_en = en;
    gmii_tx_er = er;
    for (int i = 0; i < 300; i++) begin
      cycle(cap);
      if (cap) return;
    end
    check("send_timeout", 8'd1, 8'd0);
  endtask

  task automatic drain();
    logic cap;
    for (int i = 0; i < 300 && sb.size() != 0; i++) cycle(cap);
    check("drain_empty", 8'(sb.size()), 8'd0);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {txd_q1, txd_q2}, 8'h00);
    check(tag, {4'h0, ctl_q1, ctl_q2, clk_q1, clk_q2}, 8'h00);
    check({tag, "_en"}, {7'h0, gmii_clk_en}, 8'h00);
  endtask

  initial begin
    logic cap;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    // Gigabit: strobe high immediately after release and every cycle.
    speed = 2'b10; gmii_txd = 8'hA5; gmii_tx_en = 1'b1; gmii_tx_er = 1'b0;
    rst = 1'b0;
    #1;
    check("clk_en_release", {7'h0, gmii_clk_en}, 8'h01);
    repeat (4) send(2'b10, 8'hA5, 1'b1, 1'b0);
    send(2'b10, 8'h5D, 1'b1, 1'b1);
    send(2'b10, 8'h00, 1'b0, 1'b0);
    send(2'b10, 8'hF1, 1'b0, 1'b1);

    // 100M, two bytes back to back.
    send(2'b01, 8'h3C, 1'b1, 1'b0);
    send(2'b01, 8'h3C, 1'b1, 1'b0);

    // 10M with tx_er.
    send(2'b00, 8'h7E, 1'b1, 1'b1);

    // 100M -> 1000M while a 100M byte is in flight.
    send(2'b01, 8'h96, 1'b1, 1'b0);
    send(2'b10, 8'h42, 1'b1, 1'b0);
    send(2'b10, 8'h24, 1'b0, 1'b0);

    // Reset mid-byte at cnt=3, phase=1.
    send(2'b01, 8'hB7, 1'b1, 1'b0);
    repeat (8) cycle(cap);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("mid_reset");
    sb.delete();
    rst = 1'b0;
    #1;
    check("clk_en_after_rst", {7'h0, gmii_clk_en}, 8'h01);

    // speed=11 behaves as gigabit.
    send(2'b11, 8'hA5, 1'b1, 1'b0);
    send(2'b11, 8'hC3, 1'b1, 1'b1);
    send(2'b01, 8'h81, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rgmii_tx_ddr_fmt.md
Name: rgmii_tx_ddr_fmt

Overview:
- Transmit-side partner of the source-synchronous DDR input path in the Ethernet PHY interface.
- Converts a GMII byte stream (txd/tx_en/tx_er) plus a link-speed select into per-edge q1/q2 pairs that drive downstream oddr instances: data nibbles, RGMII TX_CTL and the forwarded TX clock.
- Handles 1000 Mb/s DDR, and 10/100 Mb/s nibble-SDR with clock-enable strobes back to the MAC.
- Sits between the MAC tx path and the oddr/pin layer, all in the 125 MHz tx clock domain.

Parameters:
- CLK_DIV_100, 5, clk cycles per RGMII clock period at 100 Mb/s (>=2).
- CLK_DIV_10, 50, clk cycles per RGMII clock period at 10 Mb/s (>=2).

Ports:
- clk  input  1  tx clock, 125 MHz; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- speed  input  2  00=10M, 01=100M, 10=1000M, 11=treated as 1000M.
- gmii_txd  input  8  tx byte.
- gmii_tx_en  input  1  tx enable.
- gmii_tx_er  input  1  tx error.
- gmii_clk_en  output  1  byte-accept strobe; the MAC must present the next byte while it is high.
- txd_q1  output  4  nibble for the rising-edge oddr input.
- txd_q2  output  4  nibble for the falling-edge oddr input.
- ctl_q1  output  1  TX_CTL, rising half.
- ctl_q2  output  1  TX_CTL, falling half.
- clk_q1  output  1  forwarded-clock pattern, rising half.
- clk_q2  output  1  forwarded-clock pattern, falling half.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. The 90-degree clock skew is external (oddr/IDELAY/PHY) and outside this block.
- Internal state:
  - spd_lat: latched speed.
  - cnt: 0..N-1, where N = CLK_DIV_100 or CLK_DIV_10 per spd_lat.
  - phase: 0 = low nibble, 1 = high nibble.
  - hold_hi[3:0]: high nibble held for the second half of the byte.
- Reset: spd_lat=10 (1000M), cnt=0, phase=0, hold_hi=0. All q outputs are 0. gmii_clk_en=0 while rst is high.
- gmii_clk_en (combinational from registers) = ~rst & (spd_lat is 1000M | (cnt==N-1 & phase==1)).
  - Consequence: gmii_clk_en=1 in the first cycle after reset release.
- Capture edge = any rising edge with gmii_clk_en=1. At a capture edge:
  - spd_lat <= speed; cnt <= 0; phase <= 0; hold_hi <= txd[7:4].
  - ctl_q1 <= tx_en; ctl_q2 <= tx_en ^ tx_er.
  - New speed 1000M: txd_q1 <= txd[3:0]; txd_q2 <= txd[7:4]; clk_q1,clk_q2 <= 1,0.
  - New speed 10/100: txd_q1 = txd_q2 <= txd[3:0]; clk pattern is taken for cnt=0.
- Non-capture edge (10/100 only):
  - cnt increments. On wrap N-1 -> 0 with phase 0: phase <= 1 and txd_q1 = txd_q2 <= hold_hi.
  - ctl outputs are unchanged.
- Clock pattern for cnt value c, with H = N/2 (integer division):
  - c < H: clk_q1,clk_q2 = 1,1.
  - c == H and N odd: 1,0.
  - Otherwise: 0,0.
  - Result: 50% duty cycle to half-cycle resolution (N=5: 11,11,10,00,00).
- Latency: outputs update at the capture edge. One byte occupies 1 cycle at 1000M, 2N cycles at 10/100M.
- Speed changes take effect only at a capture edge, never mid-byte. The byte captured at an edge is sent at the speed latched at that same edge.
- rst asserted mid-byte: the state returns to the reset values at that edge and the byte is truncated. This is acceptable (the MAC is reset together with this block).

Decomposition:
- Shared eth package: speed encodings SPEED_10=2'b00, SPEED_100=2'b01, SPEED_1000=2'b10.
- Optional sub-module rgmii_clk_pattern (input cnt and N; output clk q1/q2), kept combinational and reusable by the rx-side clock checker.
- Everything else lives in one module.

Test Plan:
- Reset, then release with speed=10 and txd=0xA5, tx_en=1, tx_er=0 held -> gmii_clk_en=1 every cycle; txd_q1=5, txd_q2=A, ctl_q1=1, ctl_q2=1, clk_q=1/0 each cycle after the first capture.
- speed=01, byte 0x3C, tx_en=1 -> txd_q1=txd_q2=C for 5 cycles, then 3 for 5 cycles; clk_q sequence 11,11,10,00,00 repeating; gmii_clk_en high exactly once per 10 cycles.
- speed=00, byte 0x7E, tx_er=1 -> nibble E for 50 cycles, then 7 for 50; clk_q high for 25 of every 50 cycles; ctl_q1=1, ctl_q2=0; strobe period 100 cycles.
- Switch speed 01->10 mid-byte -> the 100M byte completes its full 10 cycles; 1000M begins at the next strobe.
- Assert rst for 1 cycle at cnt=3, phase=1 -> all q outputs are 0 the next cycle; gmii_clk_en=1 in the cycle after rst falls.
- speed=11 -> identical outputs to speed=10.
